// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing generator with registered, mutually aligned outputs.
// Define VGA_CLK_DIV2_EN to advance the raster every other clk (50 MHz board clock).
`timescale 1ns/1ps

module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pixel_ce,
    output logic       hsync,
    output logic       vsync,
    output logic       display_en,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // Decode bounds are 11 bits wide so a limit of exactly 1024 still compares correctly.
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic       tick;
    logic [9:0] h_q, v_q, h_d, v_d;
    logic [10:0] h_ext, v_ext;
    logic       de_d, hs_d, vs_d, ls_d, fs_d;
    logic       ce_q, hs_q, vs_q, de_q, ls_q, fs_q;
    logic [9:0] x_q, y_q;

`ifdef VGA_CLK_DIV2_EN
    logic div_q;

    // The first edge after reset release is a tick, then every second edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= 1'b0;
        end else begin
            div_q <= ~div_q;
        end
    end

    assign tick = ~div_q;
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end
    end

    // Outputs decode the position being loaded so they line up with the counters.
    always_comb begin
        h_ext = {1'b0, h_d};
        v_ext = {1'b0, v_d};
        de_d  = (h_ext < H_ACT) && (v_ext < V_ACT);
        hs_d  = !((h_ext >= HS_START) && (h_ext < HS_END));
        vs_d  = !((v_ext >= VS_START) && (v_ext < VS_END));
        ls_d  = (h_d == '0);
        fs_d  = (h_d == '0) && (v_d == '0);
    end

    // Counters preset to the last position so the first tick wraps to (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q  <= H_LAST;
            v_q  <= V_LAST;
            ce_q <= 1'b0;
            x_q  <= '0;
            y_q  <= '0;
            de_q <= 1'b0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            ce_q <= tick;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
            if (tick) begin
                h_q  <= h_d;
                v_q  <= v_d;
                x_q  <= h_d;
                y_q  <= v_d;
                de_q <= de_d;
                hs_q <= hs_d;
                vs_q <= vs_d;
                ls_q <= ls_d;
                fs_q <= fs_d;
            end
        end
    end

    assign pixel_ce    = ce_q;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign display_en  = de_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a default-size instance for line timing and a
// shrunken instance (32x19 raster) so whole frames fit in a short run.
`timescale 1ns/1ps

module tb_vga_timing_gen;

`ifdef VGA_CLK_DIV2_EN
    localparam int CPT = 2;
`else
    localparam int CPT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic       dCe, dHs, dVs, dDe, dLs, dFs;
    logic [9:0] dX, dY;
    logic       sCe, sHs, sVs, sDe, sLs, sFs;
    logic [9:0] sX, sY;

    vga_timing_gen dut (
        .clk(clk), .rst_n(rst_n), .pixel_ce(dCe), .hsync(dHs), .vsync(dVs),
        .display_en(dDe), .pixel_x(dX), .pixel_y(dY),
        .line_start(dLs), .frame_start(dFs)
    );

    // Small raster: H 16/4/6/6 = 32 (hsync low 20..25), V 12/2/2/3 = 19 (vsync low 14..15).
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dutSmall (
        .clk(clk), .rst_n(rst_n), .pixel_ce(sCe), .hsync(sHs), .vsync(sVs),
        .display_en(sDe), .pixel_x(sX), .pixel_y(sY),
        .line_start(sLs), .frame_start(sFs)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       de, hs, vs, ls, fs;
    } vec_t;

    vec_t defQ[$];
    vec_t smlQ[$];
    vec_t monVec;

    int vectors = 0;
    int miscompares = 0;
    int defTick = -1, smlTick = -1;
    int cycle = 0, segment = 0, sinceRel = 0;
    int lastDefLs = -1, lastSmlLs = -1, lastSmlFs = -1;
    int sDeCnt = 0, sHsLow = 0, sVsLow = 0, sLsCnt = 0, sFsCnt = 0;
    int dDeCnt = 0, dHsLow = 0;
    logic prevCe = 1'b0;
    bit haveCe = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushVec(input bit toSmall, input int t, input int x, input int y,
                           input bit de, input bit hs, input bit vs, input bit ls, input bit fs);
        vec_t v;
        v.tick = t;
        v.x = 10'(x);
        v.y = 10'(y);
        v.de = de; v.hs = hs; v.vs = vs; v.ls = ls; v.fs = fs;
        if (toSmall) smlQ.push_back(v);
        else defQ.push_back(v);
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, " def"}, {dX, dY, dDe, dHs, dVs, dLs, dFs, dCe},
                    {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        checkOutput({name, " small"}, {sX, sY, sDe, sHs, sVs, sLs, sFs, sCe},
                    {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    endtask

    // Monitor: counts raster ticks per instance and pops expected vectors by tick index.
    always @(negedge clk) begin
        cycle++;
        if (!rst_n) begin
            defTick = -1; smlTick = -1;
            lastDefLs = -1; lastSmlLs = -1; lastSmlFs = -1;
            haveCe = 1'b0; sinceRel = 0;
        end else begin
            if (sinceRel < 16) begin
`ifdef VGA_CLK_DIV2_EN
                if (haveCe) checkOutput("ce toggle", dCe, prevCe ? 1'b0 : 1'b1);
`else
                checkOutput("ce high", dCe, 1'b1);
`endif
                prevCe = dCe;
                haveCe = 1'b1;
            end
            sinceRel++;

            if (dCe) begin
                defTick++;
                if (defQ.size() > 0 && defQ[0].tick == defTick) begin
                    monVec = defQ.pop_front();
                    checkOutput($sformatf("def t=%0d", monVec.tick),
                                {dX, dY, dDe, dHs, dVs, dLs, dFs},
                                {monVec.x, monVec.y, monVec.de, monVec.hs, monVec.vs, monVec.ls, monVec.fs});
                end
                if (segment == 0 && defTick <= 799) begin
                    dDeCnt += dDe;
                    dHsLow += !dHs;
                    if (defTick == 799) begin
                        checkOutput("def line de count", dDeCnt, 640);
                        checkOutput("def line hsync-low count", dHsLow, 96);
                    end
                end
                if (dLs) begin
                    if (lastDefLs >= 0) checkOutput("def line period", cycle - lastDefLs, 800 * CPT);
                    lastDefLs = cycle;
                end
            end else begin
                checkOutput("def strobes idle", {dLs, dFs}, 2'b00);
            end

            if (sCe) begin
                smlTick++;
                if (smlQ.size() > 0 && smlQ[0].tick == smlTick) begin
                    monVec = smlQ.pop_front();
                    checkOutput($sformatf("small t=%0d", monVec.tick),
                                {sX, sY, sDe, sHs, sVs, sLs, sFs},
                                {monVec.x, monVec.y, monVec.de, monVec.hs, monVec.vs, monVec.ls, monVec.fs});
                end
                if (segment == 0 && smlTick <= 607) begin
                    sDeCnt += sDe; sHsLow += !sHs; sVsLow += !sVs;
                    sLsCnt += sLs; sFsCnt += sFs;
                    if (smlTick == 607) begin
                        checkOutput("small frame de count", sDeCnt, 192);
                        checkOutput("small frame hsync-low count", sHsLow, 114);
                        checkOutput("small frame vsync-low count", sVsLow, 64);
                        checkOutput("small frame line_start count", sLsCnt, 19);
                        checkOutput("small frame frame_start count", sFsCnt, 1);
                    end
                end
                if (sLs) begin
                    if (lastSmlLs >= 0) checkOutput("small line period", cycle - lastSmlLs, 32 * CPT);
                    lastSmlLs = cycle;
                end
                if (sFs) begin
                    if (lastSmlFs >= 0) checkOutput("small frame period", cycle - lastSmlFs, 608 * CPT);
                    lastSmlFs = cycle;
                end
            end else begin
                checkOutput("small strobes idle", {sLs, sFs}, 2'b00);
            end
        end
    end

    task automatic applyStimulus();
        bit found;
        // Power-on reset, with the expected raster positions queued by tick index.
        #1 rst_n = 1'b0;
        pushVec(0, 0,    0,   0, 1, 1, 1, 1, 1);
        pushVec(0, 1,    1,   0, 1, 1, 1, 0, 0);
        pushVec(0, 639,  639, 0, 1, 1, 1, 0, 0);
        pushVec(0, 640,  640, 0, 0, 1, 1, 0, 0);
        pushVec(0, 655,  655, 0, 0, 1, 1, 0, 0);
        pushVec(0, 656,  656, 0, 0, 0, 1, 0, 0);
        pushVec(0, 751,  751, 0, 0, 0, 1, 0, 0);
        pushVec(0, 752,  752, 0, 0, 1, 1, 0, 0);
        pushVec(0, 799,  799, 0, 0, 1, 1, 0, 0);
        pushVec(0, 800,  0,   1, 1, 1, 1, 1, 0);
        pushVec(0, 1700, 100, 2, 1, 1, 1, 0, 0);
        pushVec(1, 0,    0,  0,  1, 1, 1, 1, 1);
        pushVec(1, 15,   15, 0,  1, 1, 1, 0, 0);
        pushVec(1, 16,   16, 0,  0, 1, 1, 0, 0);
        pushVec(1, 20,   20, 0,  0, 0, 1, 0, 0);
        pushVec(1, 25,   25, 0,  0, 0, 1, 0, 0);
        pushVec(1, 26,   26, 0,  0, 1, 1, 0, 0);
        pushVec(1, 384,  0,  12, 0, 1, 1, 1, 0);
        pushVec(1, 448,  0,  14, 0, 1, 0, 1, 0);
        pushVec(1, 511,  31, 15, 0, 1, 0, 0, 0);
        pushVec(1, 512,  0,  16, 0, 1, 1, 1, 0);
        pushVec(1, 607,  31, 18, 0, 1, 1, 0, 0);
        pushVec(1, 608,  0,  0,  1, 1, 1, 1, 1);
        pushVec(1, 975,  15, 11, 1, 1, 1, 0, 0);
        repeat (3) @(negedge clk);
        checkReset("reset hold");
        #2 rst_n = 1'b1;

        for (int i = 0; i < 4000 && defTick < 1800; i++) @(negedge clk);
        checkOutput("phase1 progress", defTick >= 1800, 1'b1);
        checkOutput("phase1 def queue drained", defQ.size(), 0);
        checkOutput("phase1 small queue drained", smlQ.size(), 0);
        segment = 1;

        // Mid-frame reset on the small raster at (20,10).
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (sX == 10'd20 && sY == 10'd10) found = 1'b1;
        end
        checkOutput("reach small (20,10)", found, 1'b1);
        #2 rst_n = 1'b0;
        #1 checkReset("async reset");
        pushVec(0, 0,   0,   0, 1, 1, 1, 1, 1);
        pushVec(0, 1,   1,   0, 1, 1, 1, 0, 0);
        pushVec(0, 640, 640, 0, 0, 1, 1, 0, 0);
        pushVec(0, 656, 656, 0, 0, 0, 1, 0, 0);
        pushVec(1, 0,   0,  0, 1, 1, 1, 1, 1);
        pushVec(1, 1,   1,  0, 1, 1, 1, 0, 0);
        pushVec(1, 20,  20, 0, 0, 0, 1, 0, 0);
        pushVec(1, 32,  0,  1, 1, 1, 1, 1, 0);
        repeat (3) @(negedge clk);
        checkReset("mid reset hold");
        #2 rst_n = 1'b1;

        for (int i = 0; i < 2000 && defTick < 700; i++) @(negedge clk);
        checkOutput("phase2 progress", defTick >= 700, 1'b1);
        checkOutput("phase2 def queue drained", defQ.size(), 0);
        checkOutput("phase2 small queue drained", smlQ.size(), 0);
    endtask

    initial begin
        applyStimulus();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
